bram_port_arbiter: RTL and testbench

Shares one 32-bit MicroBlaze-style BRAM port (EN / 4-bit byte-WEN / Addr / Dout / Din, 1-cycle read latency) between two requesters. Typical use: video-in pixel writer (requester 0) and a frame/status reader (requester 1) on port B of the processor BRAM block. The block has per-requester req/ack beat handshakes and round-robin ownership. An owner keeps the port for bursts of up to C_MAX_BURST beats while the other requester waits.

---
 rtl/bram_arb_pkg.sv | 22 ++
 rtl/rr_arbiter2.sv | 23 ++
 rtl/bram_port_arbiter.sv | 134 +++++++++++++
 tb/tb_bram_port_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_arb_pkg.sv
// Shared types and helpers for the two-requester BRAM port arbiter.
package bram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  typedef logic req_id_t;

  // Bits needed to hold values 0..value-1; elaborated as a constant.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the one not served last.
module rr_arbiter2
  import bram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    rr_last,
  output logic       grant_valid,
  output req_id_t    grant_id
);

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_valid = |req;
    grant_id    = 1'b0;
    case (req)
      2'b01:   grant_id = 1'b0;
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ~rr_last;
      default: grant_id = 1'b0;
    endcase
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one BRAM port between two beat-handshake requesters with round-robin
// ownership, bounded bursts and a tagged 1-deep read-return pipe.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int C_AWIDTH    = 32,
  parameter int C_DWIDTH    = 32,
  parameter int C_NUM_WE    = 4,
  parameter int C_MAX_BURST = 16
) (
  input  logic                BRAM_Clk,
  input  logic                BRAM_Rst,
  input  logic                Req0,
  input  logic [C_AWIDTH-1:0] Addr0,
  input  logic [C_NUM_WE-1:0] WEN0,
  input  logic [C_DWIDTH-1:0] Wdata0,
  output logic                Ack0,
  output logic [C_DWIDTH-1:0] Rdata0,
  output logic                Rvalid0,
  input  logic                Req1,
  input  logic [C_AWIDTH-1:0] Addr1,
  input  logic [C_NUM_WE-1:0] WEN1,
  input  logic [C_DWIDTH-1:0] Wdata1,
  output logic                Ack1,
  output logic [C_DWIDTH-1:0] Rdata1,
  output logic                Rvalid1,
  output logic                BRAM_EN,
  output logic [C_NUM_WE-1:0] BRAM_WEN,
  output logic [C_AWIDTH-1:0] BRAM_Addr,
  output logic [C_DWIDTH-1:0] BRAM_Dout,
  input  logic [C_DWIDTH-1:0] BRAM_Din,
  output logic                Busy
);

  localparam int                CNT_W     = clog2(C_MAX_BURST + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(C_MAX_BURST);
  localparam logic [CNT_W:0]    CNT_LIMIT = (CNT_W + 1)'(C_MAX_BURST);

  state_t           state, state_nxt;
  req_id_t          rr_last, rr_last_nxt;
  logic [CNT_W-1:0] beat_cnt, cnt_nxt;
  logic             rd_valid;
  req_id_t          rd_id;
  logic [C_DWIDTH-1:0] rdata0_q, rdata1_q;

  logic                owning, own_req, other_req, issue, at_limit;
  req_id_t             owner_id;
  logic [CNT_W:0]      cnt_plus;
  logic [C_NUM_WE-1:0] sel_wen;
  logic                grant_valid;
  req_id_t             grant_id;

  rr_arbiter2 u_rr (
    .req        ({Req1, Req0}),
    .rr_last    (rr_last),
    .grant_valid(grant_valid),
    .grant_id   (grant_id)
  );

  assign owning    = (state != ST_IDLE);
  assign owner_id  = (state == ST_OWN1);
  assign own_req   = owning && (owner_id ? Req1 : Req0);
  assign other_req = owner_id ? Req0 : Req1;
  assign issue     = own_req;
  assign sel_wen   = owner_id ? WEN1 : WEN0;
  assign cnt_plus  = {1'b0, beat_cnt} + (CNT_W + 1)'(1);
  assign at_limit  = (cnt_plus >= CNT_LIMIT);

  // A non-owner never reaches the port; address/data follow the owner even on idle cycles.
  assign Ack0      = (state == ST_OWN0) && Req0;
  assign Ack1      = (state == ST_OWN1) && Req1;
  assign BRAM_EN   = issue;
  assign BRAM_WEN  = issue ? sel_wen : '0;
  assign BRAM_Addr = owning ? (owner_id ? Addr1 : Addr0) : '0;
  assign BRAM_Dout = owning ? (owner_id ? Wdata1 : Wdata0) : '0;
  assign Busy      = owning;

  // Read return is tagged so a rotation right after a read cannot misroute it.
  assign Rvalid0 = rd_valid && (rd_id == 1'b0);
  assign Rvalid1 = rd_valid && (rd_id == 1'b1);
  assign Rdata0  = Rvalid0 ? BRAM_Din : rdata0_q;
  assign Rdata1  = Rvalid1 ? BRAM_Din : rdata1_q;

  always_comb begin
    state_nxt   = state;
    rr_last_nxt = rr_last;
    cnt_nxt     = beat_cnt;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (grant_valid) state_nxt = grant_id ? ST_OWN1 : ST_OWN0;
      end
      ST_OWN0, ST_OWN1: begin
        if (!own_req) begin
          rr_last_nxt = owner_id;
          cnt_nxt     = '0;
          state_nxt   = other_req ? (owner_id ? ST_OWN0 : ST_OWN1) : ST_IDLE;
        end else if (at_limit && other_req) begin
          rr_last_nxt = owner_id;
          cnt_nxt     = '0;
          state_nxt   = owner_id ? ST_OWN0 : ST_OWN1;
        end else begin
          cnt_nxt = at_limit ? CNT_MAX : cnt_plus[CNT_W-1:0];
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge BRAM_Clk or posedge BRAM_Rst) begin
    if (BRAM_Rst) begin
      state    <= ST_IDLE;
      rr_last  <= 1'b1;
      beat_cnt <= '0;
      rd_valid <= 1'b0;
      rd_id    <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state    <= state_nxt;
      rr_last  <= rr_last_nxt;
      beat_cnt <= cnt_nxt;
      rd_valid <= issue && (sel_wen == '0);
      rd_id    <= owner_id;
      if (Rvalid0) rdata0_q <= BRAM_Din;
      if (Rvalid1) rdata1_q <= BRAM_Din;
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a small behavioural BRAM (1-cycle read latency).
module tb_bram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Req0, Req1, Ack0, Ack1, Rvalid0, Rvalid1, BRAM_EN, Busy;
  logic [31:0] Addr0, Addr1, Wdata0, Wdata1, Rdata0, Rdata1;
  logic [31:0] BRAM_Addr, BRAM_Dout, BRAM_Din;
  logic [3:0]  WEN0, WEN1, BRAM_WEN;

  int n_vec  = 0;
  int n_miss = 0;

  logic [31:0] mem [0:255];
  logic [31:0] bram_q = '0;

  always #5 clk = ~clk;

  bram_port_arbiter #(
    .C_AWIDTH(32), .C_DWIDTH(32), .C_NUM_WE(4), .C_MAX_BURST(4)
  ) dut (
    .BRAM_Clk(clk), .BRAM_Rst(rst),
    .Req0(Req0), .Addr0(Addr0), .WEN0(WEN0), .Wdata0(Wdata0),
    .Ack0(Ack0), .Rdata0(Rdata0), .Rvalid0(Rvalid0),
    .Req1(Req1), .Addr1(Addr1), .WEN1(WEN1), .Wdata1(Wdata1),
    .Ack1(Ack1), .Rdata1(Rdata1), .Rvalid1(Rvalid1),
    .BRAM_EN(BRAM_EN), .BRAM_WEN(BRAM_WEN), .BRAM_Addr(BRAM_Addr),
    .BRAM_Dout(BRAM_Dout), .BRAM_Din(BRAM_Din), .Busy(Busy)
  );

  // Read-first BRAM with byte enables.
  always @(posedge clk) begin
    if (BRAM_EN) begin
      for (int b = 0; b < 4; b++)
        if (BRAM_WEN[b]) mem[BRAM_Addr[9:2]][8*b +: 8] <= BRAM_Dout[8*b +: 8];
      bram_q <= mem[BRAM_Addr[9:2]];
    end
  end
  assign BRAM_Din = bram_q;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    Req0 = 0; Addr0 = '0; WEN0 = '0; Wdata0 = '0;
    Req1 = 0; Addr1 = '0; WEN1 = '0; Wdata1 = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    Req0 = 1; Req1 = 1; Addr0 = 32'h40; WEN0 = 4'hF; Wdata0 = 32'h1234;
    #1;
    n_vec++;
    if ({Ack0, Ack1, Rvalid0, Rvalid1, BRAM_EN, BRAM_WEN, Busy} !== 10'b0) begin
      $display("FAIL reset_ctrl: got %b, want 0", {Ack0, Ack1, Rvalid0, Rvalid1, BRAM_EN, BRAM_WEN, Busy});
      n_miss++;
    end
    n_vec++;
    if ({Rdata0, Rdata1, BRAM_Addr, BRAM_Dout} !== 128'b0) begin
      $display("FAIL reset_data: got %h %h %h %h, want 0", Rdata0, Rdata1, BRAM_Addr, BRAM_Dout);
      n_miss++;
    end
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_write0();
    tick();
    Req0 = 1; Addr0 = 32'h100; WEN0 = 4'hF; Wdata0 = 32'hDEADBEEF;
    #1;
    n_vec++;
    if (Ack0 !== 1'b0 || Busy !== 1'b0) begin
      $display("FAIL wr0_idle: Ack0=%b Busy=%b, want 0 0", Ack0, Busy); n_miss++;
    end
    tick();
    n_vec++;
    if ({Ack0, BRAM_EN, BRAM_WEN, Busy} !== 7'b11_1111_1) begin
      $display("FAIL wr0_ack: Ack0/EN/WEN/Busy=%b, want 1111111", {Ack0, BRAM_EN, BRAM_WEN, Busy}); n_miss++;
    end
    n_vec++;
    if (BRAM_Addr !== 32'h100 || BRAM_Dout !== 32'hDEADBEEF) begin
      $display("FAIL wr0_bus: addr=%h dout=%h, want 00000100 deadbeef", BRAM_Addr, BRAM_Dout); n_miss++;
    end
    tick();
    Req0 = 0;
    #1;
    n_vec++;
    if (Rvalid0 !== 1'b0 || BRAM_EN !== 1'b0 || BRAM_WEN !== 4'h0) begin
      $display("FAIL wr0_after: Rvalid0=%b EN=%b WEN=%h, want 0 0 0", Rvalid0, BRAM_EN, BRAM_WEN); n_miss++;
    end
    tick();
    n_vec++;
    if (Busy !== 1'b0) begin
      $display("FAIL wr0_release: Busy=%b, want 0", Busy); n_miss++;
    end
  endtask

  task automatic test_read1();
    Req1 = 1; Addr1 = 32'h100; WEN1 = 4'h0;
    #1;
    n_vec++;
    if (Ack1 !== 1'b0) begin
      $display("FAIL rd1_idle: Ack1=%b, want 0", Ack1); n_miss++;
    end
    tick();
    n_vec++;
    if ({Ack1, Ack0, BRAM_EN, BRAM_WEN} !== 7'b1010000 || BRAM_Addr !== 32'h100) begin
      $display("FAIL rd1_ack: Ack1/Ack0/EN/WEN=%b addr=%h, want 1010000 00000100", {Ack1, Ack0, BRAM_EN, BRAM_WEN}, BRAM_Addr); n_miss++;
    end
    tick();
    Req1 = 0;
    #1;
    n_vec++;
    if (Rvalid1 !== 1'b1 || Rdata1 !== 32'hDEADBEEF || Rvalid0 !== 1'b0) begin
      $display("FAIL rd1_data: Rvalid1=%b Rdata1=%h Rvalid0=%b, want 1 deadbeef 0", Rvalid1, Rdata1, Rvalid0); n_miss++;
    end
    tick();
    n_vec++;
    if (Rvalid1 !== 1'b0 || Rdata1 !== 32'hDEADBEEF) begin
      $display("FAIL rd1_hold: Rvalid1=%b Rdata1=%h, want 0 deadbeef", Rvalid1, Rdata1); n_miss++;
    end
  endtask

  task automatic test_tie();
    do_reset();
    tick();
    Req0 = 1; Addr0 = 32'h104; WEN0 = 4'hF; Wdata0 = 32'h11111111;
    Req1 = 1; Addr1 = 32'h104; WEN1 = 4'h0;
    #1;
    n_vec++;
    if ({Ack0, Ack1} !== 2'b00) begin
      $display("FAIL tie_idle: Ack0/Ack1=%b, want 00", {Ack0, Ack1}); n_miss++;
    end
    tick();
    n_vec++;
    if ({Ack0, Ack1} !== 2'b10) begin
      $display("FAIL tie_first: Ack0/Ack1=%b, want 10", {Ack0, Ack1}); n_miss++;
    end
    tick();
    Req0 = 0;
    #1;
    n_vec++;
    if ({Ack0, Ack1, BRAM_EN} !== 3'b000) begin
      $display("FAIL tie_gap: Ack0/Ack1/EN=%b, want 000", {Ack0, Ack1, BRAM_EN}); n_miss++;
    end
    tick();
    n_vec++;
    if (Ack1 !== 1'b1 || BRAM_Addr !== 32'h104) begin
      $display("FAIL tie_second: Ack1=%b addr=%h, want 1 00000104", Ack1, BRAM_Addr); n_miss++;
    end
    tick();
    Req1 = 0;
    #1;
    n_vec++;
    if (Rvalid1 !== 1'b1 || Rdata1 !== 32'h11111111) begin
      $display("FAIL tie_rdata: Rvalid1=%b Rdata1=%h, want 1 11111111", Rvalid1, Rdata1); n_miss++;
    end
    tick();
    n_vec++;
    if (Busy !== 1'b0) begin
      $display("FAIL tie_idle_end: Busy=%b, want 0", Busy); n_miss++;
    end
  endtask

  task automatic test_burst_rotation();
    logic [15:0] a0, a1;
    do_reset();
    tick();
    Req0 = 1; Addr0 = 32'h200; WEN0 = 4'hF; Wdata0 = 32'hA5A50000;
    for (int c = 0; c < 16; c++) begin
      if (c == 3) begin
        Req1 = 1; Addr1 = 32'h200; WEN1 = 4'h0;
      end
      #1;
      a0[c] = Ack0;
      a1[c] = Ack1;
      tick();
    end
    n_vec++;
    if (a0 !== 16'h1E1E) begin
      $display("FAIL burst_ack0: pattern=%h, want 1e1e", a0); n_miss++;
    end
    n_vec++;
    if (a1 !== 16'hE1E0) begin
      $display("FAIL burst_ack1: pattern=%h, want e1e0", a1); n_miss++;
    end
    clear_inputs();
  endtask

  task automatic test_saturate();
    logic [9:0] a0, a1;
    do_reset();
    tick();
    Req0 = 1; Addr0 = 32'h208; WEN0 = 4'hF; Wdata0 = 32'h5A5A0000;
    for (int c = 0; c < 10; c++) begin
      if (c == 8) begin
        Req1 = 1; Addr1 = 32'h208; WEN1 = 4'h0;
      end
      #1;
      a0[c] = Ack0;
      a1[c] = Ack1;
      tick();
    end
    n_vec++;
    if (a0 !== 10'h1FE || a1 !== 10'h200) begin
      $display("FAIL saturate: ack0=%h ack1=%h, want 1fe 200", a0, a1); n_miss++;
    end
    clear_inputs();
  endtask

  task automatic test_read_rotate();
    logic [7:0]  a0, rv0, rv1;
    logic [31:0] rd0_c5, din_c5, rd1_c6, rd0_c7;
    do_reset();
    tick();
    Req0 = 1; Addr0 = 32'h104; WEN0 = 4'h0;
    for (int c = 0; c < 8; c++) begin
      if (c == 2) begin
        Req1 = 1; Addr1 = 32'h100; WEN1 = 4'h0;
      end
      #1;
      a0[c]  = Ack0;
      rv0[c] = Rvalid0;
      rv1[c] = Rvalid1;
      if (c == 5) begin rd0_c5 = Rdata0; din_c5 = BRAM_Din; end
      if (c == 6) rd1_c6 = Rdata1;
      if (c == 7) rd0_c7 = Rdata0;
      tick();
    end
    n_vec++;
    if (a0 !== 8'h1E) begin
      $display("FAIL rrot_ack0: pattern=%h, want 1e", a0); n_miss++;
    end
    n_vec++;
    if (rv0 !== 8'h3C || rv1 !== 8'hC0) begin
      $display("FAIL rrot_rvalid: rv0=%h rv1=%h, want 3c c0", rv0, rv1); n_miss++;
    end
    n_vec++;
    if (rd0_c5 !== 32'h11111111 || rd0_c5 !== din_c5) begin
      $display("FAIL rrot_rdata0: Rdata0=%h Din=%h, want 11111111 11111111", rd0_c5, din_c5); n_miss++;
    end
    n_vec++;
    if (rd1_c6 !== 32'hDEADBEEF || rd0_c7 !== 32'h11111111) begin
      $display("FAIL rrot_route: Rdata1=%h Rdata0=%h, want deadbeef 11111111", rd1_c6, rd0_c7); n_miss++;
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick();
    Req0 = 1; Addr0 = 32'h104; WEN0 = 4'h0;
    tick();
    tick();
    n_vec++;
    if (Rvalid0 !== 1'b1) begin
      $display("FAIL rmid_pending: Rvalid0=%b, want 1", Rvalid0); n_miss++;
    end
    #1;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({Ack0, Ack1, Rvalid0, Rvalid1, BRAM_EN, BRAM_WEN, Busy} !== 10'b0 || BRAM_Addr !== 32'h0) begin
      $display("FAIL rmid_async: ctrl=%b addr=%h, want 0 0",
               {Ack0, Ack1, Rvalid0, Rvalid1, BRAM_EN, BRAM_WEN, Busy}, BRAM_Addr); n_miss++;
    end
    #1;
    rst = 1'b0;
    #1;
    n_vec++;
    if (Ack0 !== 1'b0 || Busy !== 1'b0) begin
      $display("FAIL rmid_idle: Ack0=%b Busy=%b, want 0 0", Ack0, Busy); n_miss++;
    end
    tick();
    n_vec++;
    if (Ack0 !== 1'b1 || Rvalid0 !== 1'b0) begin
      $display("FAIL rmid_regrant: Ack0=%b Rvalid0=%b, want 1 0", Ack0, Rvalid0); n_miss++;
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    clear_inputs();
    test_reset();
    test_write0();
    test_read1();
    test_tie();
    test_burst_rotation();
    test_saturate();
    test_read_rotate();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
